vector_seq_ctrl: RTL

- Sequences stored input vectors into a combinational benchmark circuit (default sized for c499: 41 in / 32 out) and captures each response.
- Compares each response against a stored golden response and counts mismatches.
- Sits between the vector/golden ROMs and the circuit under test in aging runs; replaces free-running per-clock vector application with a fixed apply/settle/capture cadence.

---
 rtl/vector_seq_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/vector_seq_ctrl.sv
// Vector sequencer for a combinational circuit under test: fetch, apply, settle, capture and
// compare each stored vector against its golden response, counting mismatches.
module vector_seq_ctrl #(
  parameter int unsigned IN_W       = 41,
  parameter int unsigned OUT_W      = 32,
  parameter int unsigned DEPTH      = 7,
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned ERR_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] vec_addr,
  input  logic [IN_W-1:0]   vec_rdata,
  input  logic [OUT_W-1:0]  exp_rdata,
  output logic [IN_W-1:0]   dut_in,
  input  logic [OUT_W-1:0]  dut_out,
  output logic              cap_valid,
  output logic [OUT_W-1:0]  cap_data,
  output logic [ADDR_W-1:0] cap_idx,
  output logic              cap_mismatch,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] first_err_idx,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StApply,
    StSettle,
    StCapture,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  idx_q;
  logic [CNT_W-1:0]   settle_q;
  logic [OUT_W-1:0]   exp_q;
  logic               do_start, do_apply, do_capture;
  logic               last_vec, mismatch;

  assign last_vec = (idx_q == ADDR_W'(DEPTH - 1));
  assign mismatch = (dut_out != exp_q);
  assign busy     = (state_q != StIdle) && (state_q != StDone);
  assign done     = (state_q == StDone);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Abort beats everything while busy; in IDLE/DONE it only matters when paired with start.
  always_comb begin
    state_d    = state_q;
    do_start   = 1'b0;
    do_apply   = 1'b0;
    do_capture = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          if (abort) begin
            state_d = StIdle;
          end else begin
            state_d  = StFetch;
            do_start = 1'b1;
          end
        end
      end
      StFetch: begin
        state_d = abort ? StIdle : StApply;
      end
      StApply: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          do_apply = 1'b1;
          state_d  = StSettle;
        end
      end
      StSettle: begin
        if (abort) begin
          state_d = StIdle;
        end else if (settle_q == '0) begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          do_capture = 1'b1;
          state_d    = last_vec ? StDone : StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q         <= '0;
      settle_q      <= '0;
      exp_q         <= '0;
      vec_addr      <= '0;
      dut_in        <= '0;
      cap_valid     <= 1'b0;
      cap_data      <= '0;
      cap_idx       <= '0;
      cap_mismatch  <= 1'b0;
      err_cnt       <= '0;
      first_err_idx <= '0;
    end else begin
      cap_valid <= 1'b0;
      if (do_start) begin
        idx_q         <= '0;
        vec_addr      <= '0;
        err_cnt       <= '0;
        first_err_idx <= '0;
      end
      if (do_apply) begin
        dut_in   <= vec_rdata;
        exp_q    <= exp_rdata;
        settle_q <= CNT_W'(SETTLE_CYC - 1);
      end else if (state_q == StSettle && settle_q != '0) begin
        settle_q <= settle_q - CNT_W'(1);
      end
      if (do_capture) begin
        cap_valid    <= 1'b1;
        cap_data     <= dut_out;
        cap_idx      <= idx_q;
        cap_mismatch <= mismatch;
        if (mismatch) begin
          if (err_cnt != '1) begin
            err_cnt <= err_cnt + ERR_W'(1);
          end
          if (err_cnt == '0) begin
            first_err_idx <= idx_q;
          end
        end
        // vec_addr is loaded together with idx so the ROM sees it during FETCH.
        if (!last_vec) begin
          idx_q    <= idx_q + ADDR_W'(1);
          vec_addr <= idx_q + ADDR_W'(1);
        end
      end
    end
  end

endmodule
